// File: rtl/pipe_pkg.sv
// Shared types and constants for the forwarding writeback pipeline.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // One in-flight writeback entry at the default widths.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] waddr;
        logic [DATA_W_DEF-1:0] wdata;
        logic                  ok;
    } wb_entry_t;

    // Register x0 is hardwired to zero and never forwarded.
    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    // True when a pending load at the fill stage can take the fill value this cycle.
    function automatic logic fill_applies(input logic v, input logic ok, input logic fill_valid);
        return v & ~ok & fill_valid;
    endfunction

endpackage

// File: rtl/pipe_fwd_slot.sv
// One stage register of the writeback pipeline: load, clear, vacate and late fill.
module pipe_fwd_slot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              vacate,
    input  logic              fill,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_ok,
    input  logic [DATA_W-1:0] fill_data,
    output logic              v,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              ok
);

    // Stage state: flush beats a refill, a refill beats vacating, fill only touches a held entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= 1'b0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            ok    <= 1'b0;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            v     <= 1'b1;
            we    <= ld_we;
            waddr <= ld_waddr;
            wdata <= ld_wdata;
            ok    <= ld_ok;
        end else if (vacate) begin
            v <= 1'b0;
        end else if (fill) begin
            wdata <= fill_data;
            ok    <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_fwd_chain.sv
// Elastic writeback pipeline between ALU and register file, with late load fill
// and youngest-first forwarding lookups for the decode stage.
module pipe_fwd_chain
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int N_RD       = 2,
    parameter int FILL_STAGE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_we,
    input  logic [ADDR_W-1:0]      in_waddr,
    input  logic [DATA_W-1:0]      in_wdata,
    input  logic                   in_ok,
    input  logic                   flush,
    input  logic                   fill_valid,
    input  logic [DATA_W-1:0]      fill_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_we,
    output logic [ADDR_W-1:0]      out_waddr,
    output logic [DATA_W-1:0]      out_wdata,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD-1:0]        rd_hit,
    output logic [N_RD-1:0]        rd_stall,
    output logic [N_RD*DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0]  v, we, ok;
    logic [ADDR_W-1:0] waddr [DEPTH];
    logic [DATA_W-1:0] wdata [DEPTH];

    logic [DEPTH-1:0]  adv, load, vacate, fill_en;
    logic              fill_hit;

    logic [DEPTH-1:0]  ld_we, ld_ok;
    logic [ADDR_W-1:0] ld_waddr [DEPTH];
    logic [DATA_W-1:0] ld_wdata [DEPTH];
    logic [DATA_W-1:0] eff_wdata [DEPTH];
    logic [DEPTH-1:0]  eff_ok;

    logic              found;
    logic [ADDR_W-1:0] look_addr;

    assign fill_hit  = fill_applies(v[FILL_STAGE], ok[FILL_STAGE], fill_valid);
    assign out_valid = v[DEPTH-1] & ok[DEPTH-1] & ~flush;
    assign out_we    = we[DEPTH-1];
    assign out_waddr = waddr[DEPTH-1];
    assign out_wdata = wdata[DEPTH-1];
    assign in_ready  = ~flush & (~v[0] | adv[0]);

    // Advance chain from the output backwards; a stage moves when the one ahead is empty or moving.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_valid & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    // Per-stage controls and load sources; the fill stage hands on its filled value when it moves.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            eff_wdata[i] = wdata[i];
            eff_ok[i]    = ok[i];
            fill_en[i]   = 1'b0;
            if (i == FILL_STAGE && fill_hit) begin
                eff_wdata[i] = fill_data;
                eff_ok[i]    = 1'b1;
                fill_en[i]   = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                load[i]     = in_valid & in_ready;
                ld_we[i]    = in_we;
                ld_waddr[i] = in_waddr;
                ld_wdata[i] = in_wdata;
                ld_ok[i]    = in_ok;
            end else begin
                load[i]     = adv[i-1];
                ld_we[i]    = we[i-1];
                ld_waddr[i] = waddr[i-1];
                ld_wdata[i] = eff_wdata[i-1];
                ld_ok[i]    = eff_ok[i-1];
            end
            vacate[i] = adv[i] & ~load[i];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_fwd_slot #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .clear    (flush),
            .load     (load[g]),
            .vacate   (vacate[g]),
            .fill     (fill_en[g]),
            .ld_we    (ld_we[g]),
            .ld_waddr (ld_waddr[g]),
            .ld_wdata (ld_wdata[g]),
            .ld_ok    (ld_ok[g]),
            .fill_data(fill_data),
            .v        (v[g]),
            .we       (we[g]),
            .waddr    (waddr[g]),
            .wdata    (wdata[g]),
            .ok       (ok[g])
        );
    end

    // Forwarding lookup: the youngest matching in-flight writer wins; x0 never matches.
    always_comb begin
        rd_hit    = '0;
        rd_stall  = '0;
        rd_data   = '0;
        found     = 1'b0;
        look_addr = '0;
        for (int k = 0; k < N_RD; k++) begin
            found     = 1'b0;
            look_addr = rd_addr[k*ADDR_W +: ADDR_W];
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && v[i] && we[i] && waddr[i] == look_addr && look_addr != ZERO_ADDR) begin
                    found       = 1'b1;
                    rd_hit[k]   = 1'b1;
                    rd_stall[k] = ~ok[i];
                    rd_data[k*DATA_W +: DATA_W] = ok[i] ? wdata[i] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Scoreboard bench for pipe_fwd_chain with a queue-based reference model.
module tb_pipe_fwd_chain;
    import pipe_pkg::*;

    localparam int DEPTH  = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int FILL   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 0, in_we = 0, in_ok = 0, flush = 0, fill_valid = 0, out_ready = 0;
    logic [ADDR_W-1:0] in_waddr = '0;
    logic [DATA_W-1:0] in_wdata = '0, fill_data = '0;
    logic [N_RD*ADDR_W-1:0] rd_addr = '0;
    logic in_ready, out_valid, out_we;
    logic [ADDR_W-1:0] out_waddr;
    logic [DATA_W-1:0] out_wdata;
    logic [N_RD-1:0] rd_hit, rd_stall;
    logic [N_RD*DATA_W-1:0] rd_data;

    pipe_fwd_chain #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .FILL_STAGE(FILL)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_waddr(in_waddr), .in_wdata(in_wdata), .in_ok(in_ok), .flush(flush),
        .fill_valid(fill_valid), .fill_data(fill_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_stall(rd_stall), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight entries oldest first, each with its stage position.
    typedef struct {
        int id;
        int stage;
    } pos_t;

    pos_t      mq[$];
    wb_entry_t ent[4096];
    int        sb_q[$];
    int        ns_q[$];
    bit        ns_fire;
    int        next_id = 0;
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_out_valid();
        return mq.size() > 0 && mq[0].stage == DEPTH - 1 && ent[mq[0].id].ok && !flush;
    endfunction

    // Where every entry will sit after the coming edge: each moves one step if the
    // place ahead is free once the entry ahead of it has moved.
    function automatic void plan();
        int limit = DEPTH;
        ns_q.delete();
        ns_fire = 1'b0;
        for (int j = 0; j < mq.size(); j++) begin
            int s = mq[j].stage;
            if (j == 0 && s == DEPTH - 1 && m_out_valid() && out_ready) begin
                ns_fire = 1'b1;
                ns_q.push_back(DEPTH);
            end else if (s + 1 < limit) begin
                ns_q.push_back(s + 1);
                limit = s + 1;
            end else begin
                ns_q.push_back(s);
                limit = s;
            end
        end
    endfunction

    function automatic bit m_in_ready();
        if (flush) return 1'b0;
        plan();
        if (ns_q.size() == 0) return 1'b1;
        return ns_q[ns_q.size()-1] > 0;
    endfunction

    task automatic model_update();
        bit acc;
        int id;
        if (flush) begin
            mq.delete();
            sb_q.delete();
            return;
        end
        acc = in_valid && m_in_ready();
        plan();
        for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].stage == FILL && !ent[mq[j].id].ok && fill_valid) begin
                ent[mq[j].id].ok    = 1'b1;
                ent[mq[j].id].wdata = fill_data;
            end
        end
        for (int j = 0; j < mq.size(); j++) mq[j].stage = ns_q[j];
        if (ns_fire) void'(mq.pop_front());
        if (acc) begin
            id = next_id % 4096;
            next_id++;
            ent[id].we    = in_we;
            ent[id].waddr = in_waddr;
            ent[id].wdata = in_ok ? in_wdata : '0;
            ent[id].ok    = in_ok;
            mq.push_back('{id: id, stage: 0});
            sb_q.push_back(id);
        end
    endtask

    task automatic check_comb();
        logic [ADDR_W-1:0] a;
        bit eh, es;
        logic [DATA_W-1:0] ed;
        chk("in_ready", in_ready, m_in_ready());
        chk("out_valid", out_valid, m_out_valid());
        if (m_out_valid()) chk("out_waddr_now", out_waddr, ent[mq[0].id].waddr);
        for (int k = 0; k < N_RD; k++) begin
            a  = rd_addr[k*ADDR_W +: ADDR_W];
            eh = 0; es = 0; ed = '0;
            for (int j = mq.size() - 1; j >= 0; j--) begin
                if (ent[mq[j].id].we && ent[mq[j].id].waddr == a && a != 0) begin
                    eh = 1;
                    es = !ent[mq[j].id].ok;
                    ed = ent[mq[j].id].ok ? ent[mq[j].id].wdata : '0;
                    break;
                end
            end
            chk($sformatf("rd_hit%0d", k), rd_hit[k], eh);
            chk($sformatf("rd_stall%0d", k), rd_stall[k], es);
            chk($sformatf("rd_data%0d", k), rd_data[k*DATA_W +: DATA_W], ed);
        end
    endtask

    task automatic step(input bit iv, input bit we, input int wa, input logic [31:0] wd,
                        input bit ok, input bit fl, input bit fv, input logic [31:0] fd,
                        input bit ordy, input int ra0, input int ra1);
        @(posedge clk);
        model_update();
        #1;
        in_valid   = iv;
        in_we      = we;
        in_waddr   = ADDR_W'(wa);
        in_wdata   = wd;
        in_ok      = ok;
        flush      = fl;
        fill_valid = fv;
        fill_data  = fd;
        out_ready  = ordy;
        rd_addr    = {ADDR_W'(ra1), ADDR_W'(ra0)};
        #1;
        check_comb();
    endtask

    task automatic push(input int wa, input logic [31:0] wd, input bit ok, input bit ordy);
        step(1, 1, wa, wd, ok, 0, 0, 0, ordy, wa, 0);
    endtask

    task automatic idle(input int n, input int ra);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, ra, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        model_update();
        #3;
        rst = 1'b1;
        in_valid = 0; flush = 0; fill_valid = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rd_hit", rd_hit, '0);
        mq.delete();
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    // Scoreboard monitor: every accepted writeback must match the next expected entry.
    always @(negedge clk) begin
        int id;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write actual_waddr=%0d required=none", out_waddr);
            end else begin
                id = sb_q.pop_front();
                chk("wb_we", out_we, ent[id].we);
                chk("wb_waddr", out_waddr, ent[id].waddr);
                chk("wb_wdata", out_wdata, ent[id].wdata);
            end
        end
    end

    initial begin
        rd_addr = {ADDR_W'(5), ADDR_W'(7)};
        #2;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_rd_hit", rd_hit, '0);
        chk("reset_rd_stall", rd_stall, '0);
        chk("reset_rd_data", rd_data, '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Stream of four writes to x5.
        for (int i = 1; i <= 4; i++) push(5, i, 1, 1);
        idle(4, 5);

        // Fill the pipe, then stall the consumer for three cycles while offering more.
        for (int i = 0; i < 3; i++) push(10 + i, 32'h100 + i, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 20, 32'h999, 1, 0, 0, 0, 0, 11, 12);
        idle(5, 20);

        // Forward priority: two writers of x7 in flight, youngest value must win.
        push(7, 32'h11, 1, 1);
        push(1, 32'h55, 1, 1);
        push(7, 32'h22, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        chk("fwd_prio_data", rd_data[DATA_W-1:0], 32'h22);
        chk("fwd_x0_nohit", rd_hit[1], 1'b0);
        idle(3, 7);

        // Load: stall at stage 0 and 1, fill at stage 1 while it advances.
        push(9, 32'hdead, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hABCD, 1, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        chk("fill_stall_clear", rd_stall[0], 1'b0);
        idle(3, 9);

        // Unfilled load reaches the last stage and backs up the chain, then flush with input offered.
        push(10, 0, 0, 1);
        idle(3, 10);
        push(11, 32'h1111, 1, 1);
        push(12, 32'h2222, 1, 1);
        idle(2, 11);
        step(1, 1, 13, 32'h3333, 1, 1, 0, 0, 1, 10, 13);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 10);
        chk("flush_empty_hit", rd_hit, '0);
        idle(4, 13);

        // Asynchronous reset in the middle of a stream.
        push(3, 32'h33, 1, 1);
        push(4, 32'h44, 1, 1);
        push(6, 32'h66, 1, 1);
        async_reset();
        idle(4, 3);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7),
                 $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7));
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        idle(4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
